// File: rtl/fir4_pkg.sv
// Shared types and width helpers for the fir4 inverse decoder.
package fir4_pkg;

    localparam int FIR4_TAPS = 4;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fir4inv_state_t;

    function automatic int SUM_W(input int w);
        return w + 2;
    endfunction

    function automatic int DIFF_W(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/fir4inv_hist.sv
// Four-deep decoded-sample shift register; oldest entry is x[n-4].
module fir4inv_hist
    import fir4_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] xh3
);

    logic [W-1:0] xh [FIR4_TAPS];

    // NOTE: non-blocking assignments let every tap read its neighbour's old value in the same edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < FIR4_TAPS; i++) xh[i] <= '0;
        end else if (en) begin
            xh[0] <= din;
            for (int i = 1; i < FIR4_TAPS; i++) xh[i] <= xh[i-1];
        end
    end

    assign xh3 = xh[FIR4_TAPS-1];

endmodule

// File: rtl/fir4_inverse.sv
// Streaming inverse of the 4-tap moving-sum filter: x[n] = s[n] - s[n-1] + x[n-4].
// Define FIR4INV_RANGE_CHK_EN to build the range check, FAULT state and sticky err flag.
module fir4_inverse
    import fir4_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [SUM_W(W)-1:0]  s_in,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [W-1:0]         x_out,
    output logic                 err,
    output logic [15:0]          n_samples
);

    localparam int SW = SUM_W(W);
    localparam int DW = DIFF_W(W);

    fir4inv_state_t state;
    logic [SW-1:0]  s_prev;
    logic [W-1:0]   xh3;
    logic [DW-1:0]  d;
    logic           accept;
    logic           legal;
    logic           decode;

    assign d      = DW'(s_in) - DW'(s_prev) + DW'(xh3);
    assign accept = in_valid && !clr && (state != FAULT);
    assign decode = accept && legal;

`ifdef FIR4INV_RANGE_CHK_EN
    // Legal only when the two's-complement result lies in [0, 2^W-1].
    assign legal = (d[DW-1:W] == '0);

    always_ff @(posedge clk) begin
        if (rst || clr)             err <= 1'b0;
        else if (accept && !legal)  err <= 1'b1;
    end
`else
    logic unused_d_hi;
    assign unused_d_hi = ^d[DW-1:W];
    assign legal       = 1'b1;
    assign err         = 1'b0;
`endif

    fir4inv_hist #(.W(W)) u_hist (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (decode),
        .din (d[W-1:0]),
        .xh3 (xh3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            s_prev    <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
            n_samples <= '0;
        end else if (clr) begin
            // Counter survives a clear; everything else restarts.
            state     <= SYNC;
            s_prev    <= '0;
            out_valid <= 1'b0;
            x_out     <= '0;
        end else if (decode) begin
            state     <= RUN;
            s_prev    <= s_in;
            out_valid <= 1'b1;
            x_out     <= d[W-1:0];
            if (n_samples != 16'hFFFF) n_samples <= n_samples + 16'd1;
`ifdef FIR4INV_RANGE_CHK_EN
        end else if (accept) begin
            state     <= FAULT;
            out_valid <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir4_inverse.sv
// Directed self-checking bench for fir4_inverse (W=16), including a random fir4csa chain.
module tb_fir4_inverse;
    import fir4_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        clr;
    logic [17:0] s_in;
    logic        out_valid;
    logic [15:0] x_out;
    logic        err;
    logic [15:0] n_samples;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    fir4_inverse #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .s_in      (s_in),
        .clr       (clr),
        .out_valid (out_valid),
        .x_out     (x_out),
        .err       (err),
        .n_samples (n_samples)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at the same point.
    task automatic drive(input logic r, input logic c, input logic v, input logic [17:0] s);
        rst      = r;
        clr      = c;
        in_valid = v;
        s_in     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
    endtask

    task automatic beat(input string tag, input logic [17:0] s, input logic [15:0] exp_x);
        drive(1'b0, 1'b0, 1'b1, s);
        bump();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_x"}, 32'(x_out), 32'(exp_x));
    endtask

    logic [17:0] ramp_s [6] = '{18'd1, 18'd3, 18'd6, 18'd10, 18'd14, 18'd18};
    logic [17:0] imp_s  [6] = '{18'd7, 18'd7, 18'd7, 18'd7, 18'd0, 18'd0};
    logic [15:0] imp_x  [6] = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [17:0] fs_s   [5] = '{18'h0FFFF, 18'h1FFFE, 18'h2FFFD, 18'h3FFFC, 18'h3FFFC};

    initial begin
        logic [15:0] h0, h1, h2, xr;
        logic [17:0] sr;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(n_samples), 32'd0);

        // Ramp
        for (int i = 0; i < 6; i++) beat("ramp", ramp_s[i], 16'(i + 1));
        check("ramp_cnt", 32'(n_samples), 32'd6);
        drive(1'b0, 1'b0, 1'b0, 18'd99);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_hold_x", 32'(x_out), 32'd6);

        // clr together with a beat: beat dropped, counter kept
        drive(1'b0, 1'b1, 1'b1, 18'd7);
        check("clrbeat_valid", 32'(out_valid), 32'd0);
        check("clrbeat_x", 32'(x_out), 32'd0);
        check("clrbeat_cnt", 32'(n_samples), 32'd6);

        // Impulse
        for (int i = 0; i < 6; i++) begin
            beat("imp", imp_s[i], imp_x[i]);
            check("imp_err", 32'(err), 32'd0);
        end

        // Full scale
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        for (int i = 0; i < 5; i++) begin
            beat("fs", fs_s[i], 16'hFFFF);
            check("fs_err", 32'(err), 32'd0);
        end

        // Ramp with 3-cycle gaps
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        for (int i = 0; i < 6; i++) begin
            beat("gap", ramp_s[i], 16'(i + 1));
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b0, 1'b0, 18'h3FFFF);
                check("gap_valid", 32'(out_valid), 32'd0);
                check("gap_hold_x", 32'(x_out), 32'(i + 1));
            end
        end
        check("gap_cnt", 32'(n_samples), 32'(exp_cnt));

        // Range fault
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        beat("pre_fault", 18'd5, 16'd5);
`ifdef FIR4INV_RANGE_CHK_EN
        drive(1'b0, 1'b0, 1'b1, 18'd2);
        check("fault_valid", 32'(out_valid), 32'd0);
        check("fault_err", 32'(err), 32'd1);
        check("fault_state", 32'(dut.state), 32'(FAULT));
        drive(1'b0, 1'b0, 1'b1, 18'd9);
        check("fault_ign_valid", 32'(out_valid), 32'd0);
        check("fault_ign_err", 32'(err), 32'd1);
        check("fault_ign_x", 32'(x_out), 32'd5);
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        check("fault_clr_err", 32'(err), 32'd0);
        beat("post_clr", 18'd9, 16'd9);
        check("post_clr_err", 32'(err), 32'd0);
`else
        beat("wrap", 18'd2, 16'hFFFD);
        check("wrap_err", 32'(err), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        beat("post_clr", 18'd9, 16'd9);
`endif
        check("fault_cnt", 32'(n_samples), 32'(exp_cnt));

        // Reset mid-run
        beat("mid_a", 18'd9, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 18'd0);
        exp_cnt = 0;
        beat("mid_r1", 18'd1, 16'd1);
        beat("mid_r2", 18'd3, 16'd2);
        drive(1'b1, 1'b0, 1'b1, 18'd6);
        exp_cnt = 0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_x", 32'(x_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_cnt", 32'(n_samples), 32'd0);
        beat("after_rst", 18'd4, 16'd4);

        // fir4csa chain with random samples
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        h0 = '0; h1 = '0; h2 = '0;
        for (int i = 0; i < 1000; i++) begin
            xr = 16'($urandom);
            sr = 18'(xr) + 18'(h0) + 18'(h1) + 18'(h2);
            beat("chain", sr, xr);
            h2 = h1; h1 = h0; h0 = xr;
        end
        check("chain_err", 32'(err), 32'd0);
        check("chain_cnt", 32'(n_samples), 32'(exp_cnt));

        // Counter saturation
        drive(1'b0, 1'b1, 1'b0, 18'd0);
        while (exp_cnt < 65535) begin
            drive(1'b0, 1'b0, 1'b1, 18'd0);
            bump();
        end
        check("sat_reach", 32'(n_samples), 32'hFFFF);
        beat("sat_beat", 18'd0, 16'd0);
        check("sat_hold", 32'(n_samples), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir4_inverse.md
# fir4_inverse

Streaming inverse of the 4-tap moving-sum filter `fir4csa`. Each accepted sum `s[n] = x[n]+x[n-1]+x[n-2]+x[n-3]` is decoded back to the original sample with `x[n] = s[n] − s[n-1] + x[n-4]`, using zero initial history. The block sits downstream of the averaging FIR in loopback and self-check configurations, where its output must reproduce the FIR's input stream bit-exactly.

## Interface
- `w`, 16: original sample width; the sum input is `w+2` bits wide.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `s_in` carries a new sum this cycle.
- `s_in` in w+2: unsigned 4-sample sum.
- `clr` in 1: synchronous clear of history and fault; same effect as `rst` except the sample counter.
- `out_valid` out 1: `x_out` is a newly decoded sample.
- `x_out` out w: reconstructed unsigned sample.
- `err` out 1: sticky range-fault flag. Held at 0 when the range check is compiled out.
- `n_samples` out 16: count of decoded samples, saturating at 16'hFFFF.

## Operation
- History registers:
  - `s_prev` (w+2 bits), the last accepted sum.
  - `xh[0..3]` (w bits each), the last four decoded samples; `xh[3]` is `x[n-4]`.
- All history resets to 0 on `rst` or `clr`.
- Datapath:
  - `d = s_in − s_prev + xh[3]`, computed in w+3-bit two's complement.
  - A result is legal when `0 ≤ d ≤ 2^w−1`.
- States:
  - SYNC: after reset or clear. The first beat is decoded with the zero history, then the block goes to RUN.
  - RUN: every `in_valid` beat shifts `xh`, updates `s_prev`, and emits `d[w-1:0]`.
  - FAULT: entered on an illegal `d` (range check build only). No decode, no history update, `out_valid` stays 0, `err` stays 1. Leaves only on `clr` (to SYNC) or `rst`.
- `in_valid` low: history frozen, `out_valid` 0, `x_out` holds its last value.
- `clr` and `in_valid` in the same cycle: `clr` wins and the beat is dropped.
- `n_samples` increments once per `out_valid`. `clr` does not reset it; only `rst` does.
- Reset values: `out_valid` 0, `x_out` 0, `err` 0, `n_samples` 0, state SYNC.

## Timing
- Latency is one cycle: a beat accepted at edge k gives `out_valid`/`x_out` after edge k+1's register update, i.e. visible in cycle k+1.
- Throughput is one sample per cycle. There is no backpressure.
- The illegal beat itself gives `out_valid` 0 and `err` 1 in the next cycle.
- `rst` asserted mid-stream clears everything at the next edge. The beat presented in that cycle is discarded.
- History lives in plain registers with no wrap pointer. This makes the shift ordering deterministic.

## Configuration
- `FIR4INV_RANGE_CHK_EN` defined:
  - The legality comparison, the FAULT state and the `err` register are built.
- `FIR4INV_RANGE_CHK_EN` not defined:
  - `d` is truncated to w bits with no check.
  - FAULT is unreachable and removed.
  - `err` is tied to 0.

## Structure
- Shared package `fir4_pkg` holds:
  - the state enum `fir4inv_state_t` (SYNC, RUN, FAULT);
  - the localparam `FIR4_TAPS = 4`;
  - width helpers `SUM_W(w) = w+2` and `DIFF_W(w) = w+3`.
- One sub-module, `fir4inv_hist`: the 4-deep sample shift register with enable and clear, exposing `xh[3]`.
- The FSM, datapath and counter live in the top.

## Test plan
All cases use w=16.
- **Ramp:** after `rst`, feed `s_in` = 1, 3, 6, 10, 14, 18 on consecutive cycles → `x_out` = 1, 2, 3, 4, 5, 6, each one cycle later; `n_samples` = 6.
- **Impulse:** feed sums 7, 7, 7, 7, 0, 0 → `x_out` = 7, 0, 0, 0, 0, 0; `err` stays 0.
- **Full scale:** feed 0x0FFFF, 0x1FFFE, 0x2FFFD, 0x3FFFC, 0x3FFFC → `x_out` = 0xFFFF every beat, with no fault.
- **Gaps and chaining:**
  - Ramp with `in_valid` low for 3 cycles between beats → identical `x_out` sequence, `out_valid` low in the gaps.
  - Chain `fir4csa` → `fir4_inverse` with 1000 random samples → output equals the input delayed.
- **Fault (check built):**
  - Feed 5 then 2 → d = −3 → `err` = 1, state FAULT, later beats ignored.
  - Pulse `clr`, then feed 9 → `x_out` = 9, `err` = 0.
- **Reset mid-run:**
  - Assert `rst` during the ramp at beat 3 → all outputs 0 next cycle, `n_samples` = 0.
  - The next beat of 4 → `x_out` = 4.
